// File: rtl/pio_in_pkg.sv
// Shared definitions for the input PIO: register word addresses, the
// debounce counter width and the register-index type used by the slave decode.
package pio_in_pkg;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t ADDR_DATA = 3'd0;
    localparam reg_idx_t ADDR_MASK = 3'd2;
    localparam reg_idx_t ADDR_EDGE = 3'd3;
    localparam reg_idx_t ADDR_RISE = 3'd4;
    localparam reg_idx_t ADDR_FALL = 3'd5;

    localparam int unsigned DB_CNT_W = 16;

endpackage

// File: rtl/pio_in_debounce.sv
// Single-bit debounce cell: dout follows din only after din has differed
// from the current stable value for DB_CYCLES consecutive clocks.
// Ports: clk, reset (sync, active-high), din (synchronised bit), dout (stable bit).
module pio_in_debounce
    import pio_in_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [DB_CNT_W-1:0] db_cnt;
    logic                db_q;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt <= '0;
            db_q   <= 1'b0;
        end else if (din != db_q) begin
            if (db_cnt == DB_CNT_W'(DB_CYCLES - 1)) begin
                db_q   <= din;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_CNT_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM slave input PIO with synchroniser, per-bit rise/fall edge
// selection, W1C edge capture, interrupt masking and post-reset priming
// that suppresses spurious edges from pins already high at reset.
// Optional debounce stage enabled by defining PIO_DEBOUNCE_EN.
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   address        - word address (0 DATA, 2 MASK, 3 EDGE, 4 RISE_EN, 5 FALL_EN)
//   chipselect, write_n, writedata - Avalon-MM write interface
//   in_port        - asynchronous pin inputs
//   readdata       - registered read data, 1-cycle latency
//   irq            - interrupt request, OR of masked captured edges
module pio_in_edge_capture
    import pio_in_pkg::*;
#(
    parameter int unsigned     WIDTH       = 10,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RISE_RST   = '1,
    parameter int unsigned     DB_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned PRIME_W = 3;
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [PRIME_W-1:0] prime_cnt;
    logic             primed;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] edge_detect;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic [31:0]      rd_mux;
    logic [31:0]      unused_writedata;

    assign wr_en            = chipselect & ~write_n;
    assign wdata            = writedata[WIDTH-1:0];
    assign unused_writedata = writedata;

    // Input synchroniser, shifting from stage 0 towards the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        pio_in_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (sync_q[i]),
            .dout  (filt[i])
        );
    end
`else
    logic [15:0] unused_db_cycles;
    assign unused_db_cycles = 16'(DB_CYCLES);
    assign filt = sync_q;
`endif

    // Edge detection is held off until the synchroniser has flushed reset zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + PRIME_W'(1);
        end
    end

    assign primed = (prime_cnt == PRIME_DONE);

    assign edge_detect = {WIDTH{primed}} &
                         (((filt & ~prev) & rise_en) | ((~filt & prev) & fall_en));

    assign edge_clr = (wr_en && (address == ADDR_EDGE)) ? wdata : '0;

    // Register file, capture (new edges override a same-cycle clear) and read pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev     <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            rise_en  <= RISE_RST;
            fall_en  <= '0;
            readdata <= '0;
        end else begin
            prev     <= filt;
            edge_cap <= (edge_cap & ~edge_clr) | edge_detect;
            readdata <= rd_mux;
            if (wr_en && (address == ADDR_MASK)) irq_mask <= wdata;
            if (wr_en && (address == ADDR_RISE)) rise_en  <= wdata;
            if (wr_en && (address == ADDR_FALL)) fall_en  <= wdata;
        end
    end

    // Read mux; unmapped addresses and upper bits read zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux = 32'(filt);
            ADDR_MASK: rd_mux = 32'(irq_mask);
            ADDR_EDGE: rd_mux = 32'(edge_cap);
            ADDR_RISE: rd_mux = 32'(rise_en);
            ADDR_FALL: rd_mux = 32'(fall_en);
            default:   rd_mux = '0;
        endcase
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Directed self-checking bench for pio_in_edge_capture (default parameters).
module tb_pio_in_edge_capture;

`ifdef PIO_DEBOUNCE_EN
    localparam int DBX = 16;
`else
    localparam int DBX = 0;
`endif
    // Pin change to EDGE_CAPTURE set, in clocks (SYNC_STAGES=2).
    localparam int LAT  = 3 + DBX;
    localparam int SETL = LAT + 4;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [9:0]  in_port;
    logic [31:0] readdata;
    logic        irq;
    logic [31:0] rd;

    int n_checks = 0;
    int n_fail   = 0;

    pio_in_edge_capture dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        tick(1);
        d = readdata;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 10'h3FF;
        tick(3);
        reset = 1'b0;
        check("rst_rdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // Pins high through reset: no capture without debounce.
        tick(10 + DBX);
        bus_rd(3'd3, rd);
        check("prime_edge", rd, (DBX != 0) ? 32'h3FF : 32'h0);
        check("prime_irq", {31'b0, irq}, 32'h0);
        address = 3'd0;
        #1;
        check("rd_lat_old", readdata, (DBX != 0) ? 32'h3FF : 32'h0);
        tick(1);
        check("rd_data", readdata, 32'h3FF);
        bus_rd(3'd4, rd); check("rise_rst", rd, 32'h3FF);
        bus_rd(3'd5, rd); check("fall_rst", rd, 32'h0);
        bus_rd(3'd2, rd); check("mask_rst", rd, 32'h0);

        // Falling edges ignored with FALL_EN=0.
        in_port = 10'h000;
        tick(SETL);
        bus_wr(3'd3, 32'h3FF);
        bus_rd(3'd3, rd); check("fall_ignored", rd, 32'h0);

        // Rising edge latency on bit3.
        address    = 3'd3;
        in_port[3] = 1'b1;
        tick(LAT);
        check("rise_lat_pre", readdata, 32'h0);
        tick(1);
        check("rise_lat", readdata, 32'h008);
        in_port[3] = 1'b0;
        tick(SETL);
        bus_rd(3'd3, rd); check("bit3_fall_noop", rd, 32'h008);
        bus_wr(3'd3, 32'h3FF);
        bus_rd(3'd3, rd); check("clr_all", rd, 32'h0);

        // Fall-only on bit0, then unmask.
        bus_wr(3'd5, 32'h001);
        bus_wr(3'd4, 32'h000);
        in_port[0] = 1'b1;
        tick(SETL);
        bus_rd(3'd3, rd); check("b0_rise_noop", rd, 32'h0);
        in_port[0] = 1'b0;
        tick(SETL);
        bus_rd(3'd3, rd); check("b0_fall_cap", rd, 32'h001);
        check("irq_masked", {31'b0, irq}, 32'h0);
        bus_wr(3'd2, 32'h001);
        check("irq_set", {31'b0, irq}, 32'h1);
        bus_rd(3'd2, rd); check("mask_rb", rd, 32'h001);

        // W1C partial clear.
        bus_wr(3'd5, 32'h005);
        in_port[2] = 1'b1;
        tick(SETL);
        in_port[2] = 1'b0;
        tick(SETL);
        bus_rd(3'd3, rd); check("edge_005", rd, 32'h005);
        bus_wr(3'd3, 32'h004);
        bus_rd(3'd3, rd); check("w1c_bit2", rd, 32'h001);

        // Clear and new edge in the same cycle: set wins.
        in_port[0] = 1'b1;
        tick(SETL);
        in_port[0] = 1'b0;
        tick(LAT - 1);
        bus_wr(3'd3, 32'h001);
        bus_rd(3'd3, rd); check("set_wins", rd, 32'h001);
        bus_wr(3'd3, 32'h001);
        bus_rd(3'd3, rd); check("w1c_bit0", rd, 32'h0);

        // Re-arm irq, then reset mid-operation.
        in_port[0] = 1'b1;
        tick(SETL);
        in_port[0] = 1'b0;
        tick(SETL);
        check("irq_rearm", {31'b0, irq}, 32'h1);
        bus_rd(3'd3, rd); check("edge_pre_rst", rd, 32'h001);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst2_irq", {31'b0, irq}, 32'h0);
        check("rst2_rdata", readdata, 32'h0);
        bus_rd(3'd2, rd); check("rst2_mask", rd, 32'h0);
        bus_rd(3'd3, rd); check("rst2_edge", rd, 32'h0);
        bus_rd(3'd4, rd); check("rst2_rise", rd, 32'h3FF);
        bus_rd(3'd5, rd); check("rst2_fall", rd, 32'h0);
        bus_wr(3'd6, 32'hFFFF_FFFF);
        bus_rd(3'd6, rd); check("addr6_zero", rd, 32'h0);
        bus_wr(3'd1, 32'hFFFF_FFFF);
        bus_rd(3'd1, rd); check("addr1_zero", rd, 32'h0);

        // Rising edges after re-priming; write to DATA ignored.
        in_port = 10'h0AA;
        tick(SETL);
        bus_wr(3'd0, 32'h3FF);
        bus_rd(3'd0, rd); check("data_ro", rd, 32'h0AA);
        bus_rd(3'd3, rd); check("rearm_edges", rd, 32'h0AA);

`ifdef PIO_DEBOUNCE_EN
        // Short pulse rejected, long level accepted.
        in_port = 10'h000;
        tick(SETL);
        bus_wr(3'd3, 32'h3FF);
        in_port[2] = 1'b1;
        tick(10);
        in_port[2] = 1'b0;
        tick(SETL);
        bus_rd(3'd3, rd); check("db_short", rd, 32'h0);
        address    = 3'd3;
        in_port[2] = 1'b1;
        tick(LAT);
        check("db_lat_pre", readdata, 32'h0);
        tick(1);
        check("db_lat", readdata, 32'h004);
        tick(20 - LAT - 1);
        in_port[2] = 1'b0;
        tick(SETL);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
